seg7_scan_decoder: RTL and testbench
====================================

Name: seg7_scan_decoder

Overview:
- Reads back a multiplexed, active-low 7-segment display bus (segment lines plus one-hot digit select) and recovers the hex nibble shown on each digit.
- Inverse of the team's hex-to-segment encoder.
- Used as an on-chip monitor and self-check of display drivers, and as a scoreboard source in board-level benches.
- Filters scan glitches with per-digit stability counting and reports complete, stable frames.

Parameters:
- NUM_DIGITS, 4: number of multiplexed digits; 1..8.
- STABLE_CNT, 3: consecutive identical samples of a digit required before committing; 1..15.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- sample_en  input  1  qualifies sampling of seg_in/dig_sel this cycle.
- seg_in  input  7  segment lines, bit0=a .. bit6=g, active-low (0 = lit).
- dig_sel  input  NUM_DIGITS  active-high one-hot digit select.
- value  output  4*NUM_DIGITS  committed nibbles; digit i at [4i+3:4i].
- blank  output  NUM_DIGITS  digit i committed as blank (all segments off).
- digit_valid  output  NUM_DIGITS  digit i has committed at least once since reset.
- frame_valid  output  1  one-cycle pulse: every digit confirmed stable since the last frame.
- frame_changed  output  1  valid with frame_valid; any value/blank differs from the previous frame.
- err_code  output  1  one-cycle pulse: unrecognised segment pattern sampled.
- err_sel  output  1  one-cycle pulse: sample_en with more than one dig_sel bit set.

Behaviour:
- Reset (async, rst_n=0): value=0, blank=0, digit_valid=0, all pulses 0, candidates and counters 0, frame mask 0, previous-frame snapshot 0. Deassertion takes effect on the next edge. Reset mid-scan discards all partial state.
- Decode is combinational, exact-match only:
  - 0x40=0, 0x79=1, 0x24=2, 0x30=3, 0x19=4, 0x12=5, 0x02=6, 0x78=7, 0x00=8, 0x10=9, 0x08=A, 0x03=B, 0x46=C, 0x21=D, 0x06=E, 0x0E=F.
  - 0x7F=blank.
  - Anything else is invalid.
- A sample is taken when sample_en=1 and dig_sel is one-hot.
- dig_sel=0 or sample_en=0: no action.
- Multi-hot dig_sel: sample discarded; err_sel=1 next cycle.
- Per digit i, on a valid sample, keep a 5-bit candidate {blank,nibble} and a counter:
  - If the sample matches the candidate and the counter < STABLE_CNT: counter increments.
  - If the counter reaches STABLE_CNT: commit the candidate to value/blank, set digit_valid[i], set frame mask bit i.
  - If the counter is already at STABLE_CNT: it saturates, and each further matching sample sets mask bit i again.
  - If the sample differs from the candidate: candidate is replaced and the counter is set to 1. When STABLE_CNT=1 this commits immediately.
- On an invalid pattern for digit i: err_code=1 next cycle, counter i cleared to 0, committed value/blank retained.
- Latency: outputs update on the clock edge after the STABLE_CNT-th matching sample (registered, 1 cycle).
- Frame FSM states:
  - COLLECT: accumulate mask bits. When the mask becomes all-ones, go to REPORT.
  - REPORT: lasts one cycle. Assert frame_valid=1; set frame_changed = ({value,blank} != snapshot); load the snapshot; clear the mask; return to COLLECT.
  - Mask bits set during REPORT are retained into the next COLLECT.
- The first frame after reset reports frame_changed=1 unless every digit committed as nibble 0 with blank=0.
- Simultaneous err_code/err_sel with frame_valid is allowed; they are independent.

Decomposition:
- Shared package seg7_pkg:
  - the 16 active-low segment constants plus SEG_BLANK=7'h7F, used by both encoder and decoder;
  - a decode function returning {valid,blank,nibble};
  - FSM state typedef.
- Sub-module seg7_digit_filter: per-digit candidate, counter and commit logic, instantiated NUM_DIGITS times via generate.
- The top level holds select checking, the frame FSM and the snapshot.

Test Plan:
- Reset, scan digits 0..3 showing 0x79,0x24,0x30,0x19, STABLE_CNT=3, three full scans -> value=16'h4321 one cycle after the 3rd scan; frame_valid pulse with frame_changed=1; digit_valid=4'hF.
- Repeat the same scans -> next frame_valid pulse with frame_changed=0, value unchanged.
- Digit 2 shows 0x24 twice, then 0x06 once, then 0x24 twice -> no commit change for digit 2, no frame_valid until a third consecutive 0x24 sample.
- Digit 1 sampled with 0x55 -> err_code pulse one cycle later; value[7:4] retained; digit 1 needs 3 fresh samples before the next frame.
- dig_sel=4'b0011 with sample_en=1 -> err_sel pulse, no state change; dig_sel=0 -> no effect.
- All digits 0x7F for 3 scans -> blank=4'hF, value unchanged; assert rst_n=0 mid-scan -> all outputs 0 immediately, then frames resume only after 3 fresh scans.

Source files
------------

// File: rtl/seg7_pkg.sv
// Shared definitions for the active-low 7-segment encoder/decoder pair.
// Segment bit 0 is segment a, bit 6 is segment g; a 0 bit lights the segment.
package seg7_pkg;

    localparam logic [6:0] SEG_0     = 7'h40;
    localparam logic [6:0] SEG_1     = 7'h79;
    localparam logic [6:0] SEG_2     = 7'h24;
    localparam logic [6:0] SEG_3     = 7'h30;
    localparam logic [6:0] SEG_4     = 7'h19;
    localparam logic [6:0] SEG_5     = 7'h12;
    localparam logic [6:0] SEG_6     = 7'h02;
    localparam logic [6:0] SEG_7     = 7'h78;
    localparam logic [6:0] SEG_8     = 7'h00;
    localparam logic [6:0] SEG_9     = 7'h10;
    localparam logic [6:0] SEG_A     = 7'h08;
    localparam logic [6:0] SEG_B     = 7'h03;
    localparam logic [6:0] SEG_C     = 7'h46;
    localparam logic [6:0] SEG_D     = 7'h21;
    localparam logic [6:0] SEG_E     = 7'h06;
    localparam logic [6:0] SEG_F     = 7'h0E;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    typedef struct packed {
        logic       valid;
        logic       blank;
        logic [3:0] nibble;
    } seg_dec_t;

    typedef enum logic {
        ST_COLLECT = 1'b0,
        ST_REPORT  = 1'b1
    } frame_state_t;

    // Exact match only; a blank digit decodes with nibble 0.
    function automatic seg_dec_t seg_decode(input logic [6:0] seg);
        seg_dec_t d;
        d = '{valid: 1'b1, blank: 1'b0, nibble: 4'h0};
        case (seg)
            SEG_0:     d.nibble = 4'h0;
            SEG_1:     d.nibble = 4'h1;
            SEG_2:     d.nibble = 4'h2;
            SEG_3:     d.nibble = 4'h3;
            SEG_4:     d.nibble = 4'h4;
            SEG_5:     d.nibble = 4'h5;
            SEG_6:     d.nibble = 4'h6;
            SEG_7:     d.nibble = 4'h7;
            SEG_8:     d.nibble = 4'h8;
            SEG_9:     d.nibble = 4'h9;
            SEG_A:     d.nibble = 4'hA;
            SEG_B:     d.nibble = 4'hB;
            SEG_C:     d.nibble = 4'hC;
            SEG_D:     d.nibble = 4'hD;
            SEG_E:     d.nibble = 4'hE;
            SEG_F:     d.nibble = 4'hF;
            SEG_BLANK: d.blank  = 1'b1;
            default:   d.valid  = 1'b0;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/seg7_digit_filter.sv
// One digit's glitch filter: a candidate pattern must be seen STABLE_CNT
// consecutive times before it is committed to the digit's outputs.
module seg7_digit_filter
    import seg7_pkg::*;
#(
    parameter int STABLE_CNT = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       sample_i,
    input  seg_dec_t   dec_i,
    output logic [3:0] value_o,
    output logic       blank_o,
    output logic       valid_o,
    output logic       commit_o
);
    localparam logic [3:0] CNT_MAX = 4'(STABLE_CNT);
    localparam logic [3:0] CNT_PRE = 4'(STABLE_CNT - 1);

    logic [4:0] cand_q, cand_d;
    logic [3:0] cnt_q, cnt_d;
    logic [3:0] value_q;
    logic       blank_q, valid_q;
    logic [4:0] code;
    logic       match;

    assign code  = {dec_i.blank, dec_i.nibble};
    assign match = (code == cand_q);

    always_comb begin
        cand_d   = cand_q;
        cnt_d    = cnt_q;
        commit_o = 1'b0;
        if (sample_i) begin
            if (!dec_i.valid) begin
                cnt_d = '0;
            end else if (match) begin
                if (cnt_q < CNT_MAX) cnt_d = cnt_q + 4'd1;
                commit_o = (cnt_q >= CNT_PRE);
            end else begin
                cand_d   = code;
                cnt_d    = 4'd1;
                commit_o = (STABLE_CNT == 1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cand_q  <= '0;
            cnt_q   <= '0;
            value_q <= '0;
            blank_q <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            cand_q <= cand_d;
            cnt_q  <= cnt_d;
            if (commit_o) begin
                // A blank commit keeps the last nibble shown.
                blank_q <= code[4];
                if (!code[4]) value_q <= code[3:0];
                valid_q <= 1'b1;
            end
        end
    end

    assign value_o = value_q;
    assign blank_o = blank_q;
    assign valid_o = valid_q;

endmodule

// File: rtl/seg7_scan_decoder.sv
// Recovers hex nibbles from a multiplexed active-low 7-segment bus and
// reports complete, stable frames.
//   state      | meaning
//   ST_COLLECT | gathering per-digit stable marks into the frame mask
//   ST_REPORT  | one cycle: pulse frame_valid, compare and load snapshot
module seg7_scan_decoder
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS = 4,
    parameter int STABLE_CNT = 3
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    sample_en,
    input  logic [6:0]              seg_in,
    input  logic [NUM_DIGITS-1:0]   dig_sel,
    output logic [4*NUM_DIGITS-1:0] value,
    output logic [NUM_DIGITS-1:0]   blank,
    output logic [NUM_DIGITS-1:0]   digit_valid,
    output logic                    frame_valid,
    output logic                    frame_changed,
    output logic                    err_code,
    output logic                    err_sel
);
    localparam logic [NUM_DIGITS-1:0] ALL_ONES = '1;

    seg_dec_t                  dec;
    logic                      sel_any, sel_multi, sample_ok;
    logic [NUM_DIGITS-1:0]     commit;
    frame_state_t              state_q, state_d;
    logic [NUM_DIGITS-1:0]     mask_q, mask_d;
    logic [5*NUM_DIGITS-1:0]   snap_q;
    logic                      err_code_q, err_sel_q;

    assign dec       = seg_decode(seg_in);
    assign sel_any   = |dig_sel;
    assign sel_multi = (dig_sel & (dig_sel - NUM_DIGITS'(1))) != '0;
    assign sample_ok = sample_en & sel_any & ~sel_multi;

    for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_digit
        seg7_digit_filter #(.STABLE_CNT(STABLE_CNT)) u_filter (
            .clk      (clk),
            .rst_n    (rst_n),
            .sample_i (sample_ok & dig_sel[i]),
            .dec_i    (dec),
            .value_o  (value[4*i +: 4]),
            .blank_o  (blank[i]),
            .valid_o  (digit_valid[i]),
            .commit_o (commit[i])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_COLLECT;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        mask_d  = mask_q | commit;
        case (state_q)
            ST_COLLECT: if ((mask_q | commit) == ALL_ONES) state_d = ST_REPORT;
            ST_REPORT: begin
                // Marks arriving during the report belong to the next frame.
                mask_d  = commit;
                state_d = ST_COLLECT;
            end
            default: state_d = ST_COLLECT;
        endcase
    end

    always_comb begin
        frame_valid   = (state_q == ST_REPORT);
        frame_changed = frame_valid && ({value, blank} != snap_q);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mask_q     <= '0;
            snap_q     <= '0;
            err_code_q <= 1'b0;
            err_sel_q  <= 1'b0;
        end else begin
            mask_q     <= mask_d;
            if (state_q == ST_REPORT) snap_q <= {value, blank};
            err_code_q <= sample_ok & ~dec.valid;
            err_sel_q  <= sample_en & sel_multi;
        end
    end

    assign err_code = err_code_q;
    assign err_sel  = err_sel_q;

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// Scoreboard bench for seg7_scan_decoder: a cycle model predicts every
// registered output and the monitor compares one cycle after each drive.
module tb_seg7_scan_decoder;
    localparam int ND = 4;
    localparam int S  = 3;
    localparam logic [6:0] TB_SEG [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                           7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    logic clk = 1'b0, rst_n = 1'b1, sample_en = 1'b0;
    logic [6:0] seg_in = 7'h7F;
    logic [ND-1:0] dig_sel = '0;
    logic [4*ND-1:0] value;
    logic [ND-1:0] blank, digit_valid;
    logic frame_valid, frame_changed, err_code, err_sel;

    seg7_scan_decoder #(.NUM_DIGITS(ND), .STABLE_CNT(S)) dut (
        .clk(clk), .rst_n(rst_n), .sample_en(sample_en), .seg_in(seg_in), .dig_sel(dig_sel),
        .value(value), .blank(blank), .digit_valid(digit_valid), .frame_valid(frame_valid),
        .frame_changed(frame_changed), .err_code(err_code), .err_sel(err_sel));

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] value;
        logic [3:0]  blank, dv;
        logic        fv, fc, ec, es;
    } exp_t;

    exp_t sb[$];
    exp_t m_exp, mon_e;
    int n_checks = 0, n_fail = 0, fv_seen = 0, fv_mark;
    logic last_fc = 1'b0;

    logic [4:0]  m_cand [ND];
    int          m_cnt  [ND];
    logic [15:0] m_val;
    logic [3:0]  m_blank, m_dv, m_mask;
    logic        m_rep;
    logic [19:0] m_snap;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %h expected %h", tag, $time, got, exp);
        end
    endtask

    function automatic int tb_dec(input logic [6:0] s);
        for (int k = 0; k < 16; k++) if (s == TB_SEG[k]) return k;
        if (s == 7'h7F) return 16;
        return -1;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < ND; k++) begin m_cand[k] = '0; m_cnt[k] = 0; end
        m_val = '0; m_blank = '0; m_dv = '0; m_mask = '0; m_rep = 1'b0; m_snap = '0;
    endtask

    task automatic model_step();
        int d, ci, ones;
        logic [4:0] code;
        logic [3:0] hit;
        logic [15:0] pv;
        logic [3:0] pb;
        hit = '0; pv = m_val; pb = m_blank; d = 0;
        ones = $countones(dig_sel);
        m_exp.es = sample_en && (ones > 1);
        m_exp.ec = 1'b0;
        if (sample_en && ones == 1) begin
            for (int k = 0; k < ND; k++) if (dig_sel[k]) d = k;
            ci = tb_dec(seg_in);
            if (ci < 0) begin
                m_cnt[d] = 0;
                m_exp.ec = 1'b1;
            end else begin
                code = (ci == 16) ? 5'h10 : 5'(ci);
                if (code == m_cand[d]) begin
                    if (m_cnt[d] < S) m_cnt[d]++;
                end else begin
                    m_cand[d] = code;
                    m_cnt[d] = 1;
                end
                if (m_cnt[d] == S) begin
                    hit[d] = 1'b1;
                    m_blank[d] = code[4];
                    if (!code[4]) m_val[4*d +: 4] = code[3:0];
                    m_dv[d] = 1'b1;
                end
            end
        end
        if (m_rep) begin
            m_snap = {pv, pb};
            m_mask = hit;
            m_rep = 1'b0;
        end else begin
            m_mask = m_mask | hit;
            m_rep = (m_mask == 4'hF);
        end
        m_exp.fv = m_rep;
        m_exp.fc = m_rep && ({m_val, m_blank} != m_snap);
        m_exp.value = m_val; m_exp.blank = m_blank; m_exp.dv = m_dv;
    endtask

    task automatic drive(input logic en, input logic [6:0] seg, input logic [3:0] sel);
        @(negedge clk);
        sample_en = en; seg_in = seg; dig_sel = sel;
        model_step();
        sb.push_back(m_exp);
    endtask

    task automatic scan(input logic [6:0] s0, input logic [6:0] s1, input logic [6:0] s2,
                        input logic [6:0] s3);
        drive(1'b1, s0, 4'b0001);
        drive(1'b1, s1, 4'b0010);
        drive(1'b1, s2, 4'b0100);
        drive(1'b1, s3, 4'b1000);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) drive(1'b0, 7'h7F, 4'b0000);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0; sample_en = 1'b0; dig_sel = '0; seg_in = 7'h7F;
        #1;
        check("rst_value", 32'(value), 32'h0);
        check("rst_blank", 32'(blank), 32'h0);
        check("rst_dvalid", 32'(digit_valid), 32'h0);
        check("rst_pulses", {28'h0, frame_valid, frame_changed, err_code, err_sel}, 32'h0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    always @(posedge clk) begin
        #1;
        if (sb.size() > 0) begin
            mon_e = sb.pop_front();
            check("value", 32'(value), 32'(mon_e.value));
            check("blank", 32'(blank), 32'(mon_e.blank));
            check("digit_valid", 32'(digit_valid), 32'(mon_e.dv));
            check("frame_valid", 32'(frame_valid), 32'(mon_e.fv));
            check("frame_changed", 32'(frame_changed), 32'(mon_e.fc));
            check("err_code", 32'(err_code), 32'(mon_e.ec));
            check("err_sel", 32'(err_sel), 32'(mon_e.es));
            if (frame_valid) begin
                fv_seen++;
                last_fc = frame_changed;
            end
        end
    end

    initial begin
        model_reset();
        do_reset();

        for (int k = 0; k < 3; k++) scan(7'h79, 7'h24, 7'h30, 7'h19);
        idle(2);
        check("first_value", 32'(value), 32'h4321);
        check("first_dvalid", 32'(digit_valid), 32'hF);
        check("first_frames", 32'(fv_seen), 32'd1);
        check("first_changed", 32'(last_fc), 32'd1);

        for (int k = 0; k < 3; k++) scan(7'h79, 7'h24, 7'h30, 7'h19);
        idle(2);
        check("repeat_frames", 32'(fv_seen), 32'd4);
        check("repeat_changed", 32'(last_fc), 32'd0);
        check("repeat_value", 32'(value), 32'h4321);

        drive(1'b1, 7'h79, 4'b0001);
        drive(1'b1, 7'h24, 4'b0010);
        drive(1'b1, 7'h19, 4'b1000);
        fv_mark = fv_seen;
        drive(1'b1, 7'h55, 4'b0100);
        drive(1'b1, 7'h24, 4'b0100);
        drive(1'b1, 7'h24, 4'b0100);
        drive(1'b1, 7'h06, 4'b0100);
        drive(1'b1, 7'h24, 4'b0100);
        drive(1'b1, 7'h24, 4'b0100);
        idle(1);
        check("glitch_frames", 32'(fv_seen), 32'(fv_mark));
        check("glitch_value", 32'(value), 32'h4321);
        drive(1'b1, 7'h24, 4'b0100);
        idle(1);
        check("third_frames", 32'(fv_seen), 32'(fv_mark + 1));
        check("third_value", 32'(value), 32'h4221);
        check("third_changed", 32'(last_fc), 32'd1);

        drive(1'b1, 7'h55, 4'b0010);
        idle(1);
        check("bad_code_value", 32'(value), 32'h4221);
        fv_mark = fv_seen;
        for (int k = 0; k < 3; k++) scan(7'h79, 7'h24, 7'h24, 7'h19);
        idle(1);
        check("fresh_frames", 32'(fv_seen), 32'(fv_mark + 1));

        drive(1'b1, 7'h79, 4'b0011);
        drive(1'b1, 7'h79, 4'b0000);
        drive(1'b0, 7'h24, 4'b0001);
        idle(1);
        check("sel_value", 32'(value), 32'h4221);

        for (int k = 0; k < 3; k++) scan(7'h7F, 7'h7F, 7'h7F, 7'h7F);
        idle(1);
        check("blank_all", 32'(blank), 32'hF);
        check("blank_value", 32'(value), 32'h4221);

        drive(1'b1, 7'h79, 4'b0001);
        drive(1'b1, 7'h24, 4'b0010);
        do_reset();
        fv_mark = fv_seen;
        for (int k = 0; k < 2; k++) scan(7'h79, 7'h24, 7'h30, 7'h19);
        idle(1);
        check("post_rst_early", 32'(fv_seen), 32'(fv_mark));
        scan(7'h79, 7'h24, 7'h30, 7'h19);
        idle(1);
        check("post_rst_frame", 32'(fv_seen), 32'(fv_mark + 1));
        check("post_rst_value", 32'(value), 32'h4321);

        idle(1);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
